cva6_lsu_issue: RTL and testbench

CVA6_LSU_ISSUE -- requirements
Module: cva6_lsu_issue

---
 rtl/cva6_lsu_issue.sv | 145 ++++++++++++++
 tb/tb_cva6_lsu_issue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_lsu_issue.sv
// rtl/cva6_lsu_issue.sv - in-order LSU issue queue with issue spacing and store commit timing
// Optional per-type issue counters are enabled by defining CVA6_LSU_ISSUE_STATS_EN.
module cva6_lsu_issue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ISSUE_GAP    = 3,
  parameter int unsigned COMMIT_DELAY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic        req_is_load_i,
  output logic        req_ready_o,
  input  logic        lsu_ready_i,
  output logic [31:0] instr_o,
  output logic        is_load_o,
  output logic        instr_valid_o,
  output logic        store_commit_o,
  output logic        empty_o
`ifdef CVA6_LSU_ISSUE_STATS_EN
  ,
  output logic [15:0] issued_loads_o,
  output logic [15:0] issued_stores_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [2:0]       GAP_C   = 3'(ISSUE_GAP);
  localparam logic [2:0]       CDLY_C  = 3'(COMMIT_DELAY);

  logic [31:0]      addr_mem [DEPTH];
  logic             load_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       gap_cnt;
  logic [2:0]       commit_cnt;
  logic             store_pending;
  logic             push;
  logic             issue;
  logic             head_load;
  logic             fifo_empty;

  // Ready comes only from the registered count: a full queue never accepts, even when popping.
  assign fifo_empty  = (count == '0);
  assign req_ready_o = (count < DEPTH_C);
  assign push        = req_valid_i && req_ready_o;
  assign head_load   = load_mem[rd_ptr];
  assign issue       = !fifo_empty && lsu_ready_i && (gap_cnt == 3'd0) &&
                       !(!head_load && store_pending);
  assign empty_o     = fifo_empty && !store_pending;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr_i;
      load_mem[wr_ptr] <= req_is_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_o <= 1'b0;
      instr_o       <= 32'd0;
      is_load_o     <= 1'b0;
    end else begin
      instr_valid_o <= issue;
      instr_o       <= issue ? addr_mem[rd_ptr] : 32'd0;
      if (issue) begin
        is_load_o <= head_load;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_cnt <= 3'd0;
    end else if (issue) begin
      gap_cnt <= GAP_C;
    end else if (gap_cnt != 3'd0) begin
      gap_cnt <= gap_cnt - 3'd1;
    end
  end

  // A store cannot issue while another is pending, so the load and the countdown never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_pending  <= 1'b0;
      commit_cnt     <= 3'd0;
      store_commit_o <= 1'b0;
    end else begin
      store_commit_o <= 1'b0;
      if (issue && !head_load) begin
        store_pending <= 1'b1;
        commit_cnt    <= CDLY_C;
      end else if (store_pending) begin
        if (commit_cnt == 3'd1) begin
          store_commit_o <= 1'b1;
          store_pending  <= 1'b0;
          commit_cnt     <= 3'd0;
        end else begin
          commit_cnt <= commit_cnt - 3'd1;
        end
      end
    end
  end

`ifdef CVA6_LSU_ISSUE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_loads_o  <= 16'd0;
      issued_stores_o <= 16'd0;
    end else if (issue) begin
      if (head_load && (issued_loads_o != 16'hFFFF)) begin
        issued_loads_o <= issued_loads_o + 16'd1;
      end
      if (!head_load && (issued_stores_o != 16'hFFFF)) begin
        issued_stores_o <= issued_stores_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cva6_lsu_issue.sv
// tb/tb_cva6_lsu_issue.sv - scoreboard bench for cva6_lsu_issue against a cycle-rule reference model
// Stats outputs are checked when CVA6_LSU_ISSUE_STATS_EN is defined.
module tb_cva6_lsu_issue;

  localparam int DEPTH = 4;
  localparam int GAP   = 3;
  localparam int CDLY  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_is_load_i;
  logic        req_ready_o;
  logic        lsu_ready_i;
  logic [31:0] instr_o;
  logic        is_load_o;
  logic        instr_valid_o;
  logic        store_commit_o;
  logic        empty_o;
`ifdef CVA6_LSU_ISSUE_STATS_EN
  logic [15:0] issued_loads_o;
  logic [15:0] issued_stores_o;
`endif

  cva6_lsu_issue #(.DEPTH(DEPTH), .ISSUE_GAP(GAP), .COMMIT_DELAY(CDLY)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_is_load_i  (req_is_load_i),
    .req_ready_o    (req_ready_o),
    .lsu_ready_i    (lsu_ready_i),
    .instr_o        (instr_o),
    .is_load_o      (is_load_o),
    .instr_valid_o  (instr_valid_o),
    .store_commit_o (store_commit_o),
    .empty_o        (empty_o)
`ifdef CVA6_LSU_ISSUE_STATS_EN
    ,
    .issued_loads_o (issued_loads_o),
    .issued_stores_o(issued_stores_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        load;
    int          acc;
  } req_t;

  req_t        exp_q[$];
  int          pulse_cyc[$];
  logic [31:0] pulse_addr[$];
  int          commit_cyc[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_pulse = -1000;
  int          store_t = -1000;
  int          m_loads = 0;
  int          m_stores = 0;
  logic        m_last_load = 1'b0;
  logic        prev_rdy = 1'b0;
  bit          rand_done = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: cycle numbers of accepts, pulses and store issues decide what must happen next.
  always @(negedge clk_i) begin
    int   cnt;
    bit   head_ok;
    bit   stall;
    bit   exp_pulse;
    bit   pend;
    req_t h;
    if (!rst_ni) begin
      chk1("rst_instr_valid", instr_valid_o, 1'b0);
      chk1("rst_store_commit", store_commit_o, 1'b0);
      chk1("rst_is_load", is_load_o, 1'b0);
      chk1("rst_req_ready", req_ready_o, 1'b1);
      chk1("rst_empty", empty_o, 1'b1);
      chk32("rst_instr", instr_o, 32'd0);
      exp_q.delete();
      last_pulse  = -1000;
      store_t     = -1000;
      m_last_load = 1'b0;
      m_loads     = 0;
      m_stores    = 0;
    end else begin
      head_ok   = (exp_q.size() > 0) && (exp_q[0].acc <= cyc - 2);
      stall     = head_ok && !exp_q[0].load && (cyc - 1 < store_t + CDLY);
      exp_pulse = head_ok && prev_rdy && (cyc - 1 >= last_pulse + GAP) && !stall;
      chk1("instr_valid", instr_valid_o, exp_pulse);
      chk1("store_commit", store_commit_o, cyc == store_t + CDLY);
      if (store_commit_o) commit_cyc.push_back(cyc);
      if (instr_valid_o) begin
        pulse_cyc.push_back(cyc);
        pulse_addr.push_back(instr_o);
      end
      if (exp_pulse) begin
        h = exp_q.pop_front();
        if (instr_valid_o) begin
          chk32("instr", instr_o, h.addr);
          chk1("is_load", is_load_o, h.load);
        end
        last_pulse  = cyc;
        m_last_load = h.load;
        if (h.load) m_loads++;
        else begin
          m_stores++;
          store_t = cyc;
        end
      end else begin
        chk32("idle_instr", instr_o, 32'd0);
        chk1("hold_is_load", is_load_o, m_last_load);
      end
      cnt = 0;
      foreach (exp_q[i]) if (exp_q[i].acc <= cyc - 1) cnt++;
      pend = (cyc >= store_t) && (cyc < store_t + CDLY);
      chk1("req_ready", req_ready_o, cnt < DEPTH);
      chk1("empty", empty_o, (cnt == 0) && !pend);
    end
    prev_rdy = lsu_ready_i;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic load, output int acc);
    bit   done;
    req_t r;
    done          = 1'b0;
    acc           = -1;
    req_valid_i   = 1'b1;
    req_addr_i    = addr;
    req_is_load_i = load;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        acc    = cyc;
        r.addr = addr;
        r.load = load;
        r.acc  = cyc;
        exp_q.push_back(r);
        done   = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    chk1("push_accepted", done, 1'b1);
  endtask

  task automatic apply_reset();
    req_valid_i = 1'b0;
    rst_ni      = 1'b0;
    idle(2);
    rst_ni      = 1'b1;
  endtask

  function automatic void clear_logs();
    pulse_cyc.delete();
    pulse_addr.delete();
    commit_cyc.delete();
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time %0t, expected end of test", $time);
    $fatal(1);
  end

  initial begin
    int          acc0;
    int          acc1;
    int          rel;
    bit          seen;
    logic [31:0] a;
    rst_ni        = 1'b1;
    req_valid_i   = 1'b0;
    req_addr_i    = 32'd0;
    req_is_load_i = 1'b0;
    lsu_ready_i   = 1'b0;
    #1;
    apply_reset();

    // single load latency
    lsu_ready_i = 1'b1;
    idle(2);
    clear_logs();
    push(32'h1000, 1'b1, acc0);
    idle(8);
    chk32("t1_pulse_count", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0) begin
      chk32("t1_latency", pulse_cyc[0], acc0 + 2);
      chk32("t1_addr", pulse_addr[0], 32'h1000);
    end

    // back-to-back stores
    clear_logs();
    push(32'h2000, 1'b0, acc0);
    push(32'h2004, 1'b0, acc1);
    idle(20);
    chk32("t2_pulse_count", pulse_cyc.size(), 2);
    chk32("t2_commit_count", commit_cyc.size(), 2);
    if (pulse_cyc.size() == 2 && commit_cyc.size() == 2) begin
      chk32("t2_first_issue", pulse_cyc[0], acc0 + 2);
      chk1("t2_store_spacing", (pulse_cyc[1] - pulse_cyc[0]) >= CDLY + 1, 1'b1);
      chk32("t2_second_issue", pulse_cyc[1], pulse_cyc[0] + GAP + 1);
      chk32("t2_commit0", commit_cyc[0], pulse_cyc[0] + CDLY);
      chk32("t2_commit1", commit_cyc[1], pulse_cyc[1] + CDLY);
    end

    // fill to full with the LSU stalled, hold a fifth request
    clear_logs();
    lsu_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h3000 + 32'(4 * i);
      push(a, i[0], acc0);
    end
    req_valid_i   = 1'b1;
    req_addr_i    = 32'h3010;
    req_is_load_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk1("t3_full_not_ready", req_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
    lsu_ready_i = 1'b1;
    rel = cyc;
    push(32'h3010, 1'b1, acc1);
    chk32("t3_fifth_accept", acc1, rel + 1);
    idle(40);
    chk32("t3_pulse_count", pulse_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < pulse_addr.size()) chk32("t3_order", pulse_addr[i], 32'h3000 + 32'(4 * i));
    end

    // two queued loads released together
    clear_logs();
    lsu_ready_i = 1'b0;
    push(32'h4000, 1'b1, acc0);
    push(32'h4004, 1'b1, acc1);
    idle(2);
    lsu_ready_i = 1'b1;
    idle(15);
    chk32("t4_pulse_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) chk32("t4_spacing", pulse_cyc[1] - pulse_cyc[0], GAP + 1);

    // reset one cycle after a store issues
    clear_logs();
    push(32'h5000, 1'b0, acc0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (instr_valid_o) seen = 1'b1;
    end
    chk1("t5_store_issued", seen, 1'b1);
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    idle(3);
    rst_ni = 1'b1;
    idle(6);
    chk32("t5_no_commit", commit_cyc.size(), 0);
    chk1("t5_empty", empty_o, 1'b1);

`ifdef CVA6_LSU_ISSUE_STATS_EN
    push(32'h6000, 1'b1, acc0);
    push(32'h6004, 1'b0, acc0);
    push(32'h6008, 1'b1, acc0);
    push(32'h600c, 1'b0, acc0);
    push(32'h6010, 1'b1, acc0);
    idle(30);
    chk32("t6_loads", {16'd0, issued_loads_o}, 32'd3);
    chk32("t6_stores", {16'd0, issued_stores_o}, 32'd2);
`endif

    // randomized traffic with a wandering LSU ready
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          push($urandom, $urandom_range(0, 1) == 1, acc0);
          idle($urandom_range(0, 3));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk_i);
          #1;
          lsu_ready_i = ($urandom_range(0, 9) < 7);
        end
      end
    join
    lsu_ready_i = 1'b1;
    idle(60);
    chk32("drain_model_empty", exp_q.size(), 0);
    chk1("drain_empty_o", empty_o, 1'b1);
`ifdef CVA6_LSU_ISSUE_STATS_EN
    chk32("stats_loads", {16'd0, issued_loads_o}, 32'(m_loads));
    chk32("stats_stores", {16'd0, issued_stores_o}, 32'(m_stores));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
